// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
// Slice width and the controller state encoding (the unused code 2'd3 is treated as IDLE).
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// nibble_add4: combinational 4-bit ripple-carry slice, zero latency, no flow control.
// c_msb is the carry into bit 3, used by the parent to derive signed overflow.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c_msb
);

    logic [4:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = w_c[4];
    assign c_msb = w_c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single 4-bit slice.
// Latency: out_valid rises NIB cycles after the accepting edge; in_ready only in IDLE.
// Backpressure: result and flags hold in DONE until out_ready; no operand queuing.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               r_c;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_s_nib;
    logic               w_co;
    logic               w_c_msb;
    logic               w_last;
    logic               w_accept;

    assign w_a_nib  = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib  = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_last   = (r_idx == IDX_W'(NIB - 1));
    assign w_accept = in_valid && in_ready;

    nibble_add4 u_slice (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .ci    (r_c),
        .s     (w_s_nib),
        .co    (w_co),
        .c_msb (w_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = in_valid ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = out_ready ? S_IDLE : S_DONE;
            default: w_state_nxt = in_valid ? S_RUN : S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    // The current nibble merged into the running sum, so zero can see the full result on the last step.
    always_comb begin
        w_sum_nxt = r_sum;
        w_sum_nxt[r_idx*NIBBLE_W +: NIBBLE_W] = w_s_nib;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub | cin;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_sum <= w_sum_nxt;
            r_c   <= w_co;
            r_idx <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_c_msb ^ w_co;
                r_zero <= (w_sum_nxt == '0);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
